// File: rtl/led_cmd_ctrl_pkg.sv
// led_cmd_ctrl_pkg: shared command codes, SPI frame field widths and executor FSM states
package led_cmd_ctrl_pkg;
  localparam int CMD_BITS = 8;
  localparam int ADDR_BITS = 8;
  localparam int PAYLOAD_BITS = 8;
  localparam int MASTER_FRAME_WIDTH = CMD_BITS + ADDR_BITS + PAYLOAD_BITS;
  localparam int BRIGHT_MAX = 100;
  localparam logic [CMD_BITS-1:0] CMD_NOP = 8'h00;
  localparam logic [CMD_BITS-1:0] CMD_WRITE = 8'h01;
  localparam logic [CMD_BITS-1:0] CMD_READ = 8'h02;
  typedef enum logic [2:0] {IDLE, CAPTURE, DECODE, WRITE, READ} state_t;
endpackage

// File: rtl/led_cmd_ctrl_pwm_channel.sv
// led_pwm_channel: one PWM output, high while the shared step is below this channel's brightness
//   sysclk/rst: clock, async active-high reset; step: shared PWM step; bright: duty; led: registered output
module led_pwm_channel #(
  parameter int SW = 7,
  parameter int BW = 7
) (
  input  logic          sysclk,
  input  logic          rst,
  input  logic [SW-1:0] step,
  input  logic [BW-1:0] bright,
  output logic          led
);
  always_ff @(posedge sysclk or posedge rst)
    if (rst) led <= 1'b0;
    else led <= 32'(step) < 32'(bright);
endmodule

// File: rtl/led_cmd_ctrl.sv
// led_cmd_ctrl: executes decoded SPI frames into LED brightness regs, PWM outputs and read responses
//   sysclk/rst: clock, async active-high reset; i_rx_dv/i_cmd/i_addr/i_payload: frame from the slave
//   o_slv_frame/o_slv_tx_enb: read response for the next transaction; o_led: PWM; o_err: sticky; o_busy: FSM active
module led_cmd_ctrl
  import led_cmd_ctrl_pkg::*;
#(
  parameter int NUM_LEDS = 4,
  parameter int PWM_STEPS = BRIGHT_MAX,
  parameter int PWM_DIV = 1250
) (
  input  logic                          sysclk,
  input  logic                          rst,
  input  logic                          i_rx_dv,
  input  logic [CMD_BITS-1:0]           i_cmd,
  input  logic [ADDR_BITS-1:0]          i_addr,
  input  logic [PAYLOAD_BITS-1:0]       i_payload,
  output logic [MASTER_FRAME_WIDTH-1:0] o_slv_frame,
  output logic                          o_slv_tx_enb,
  output logic [NUM_LEDS-1:0]           o_led,
  output logic                          o_err,
  output logic                          o_busy
);
  localparam int BW = $clog2(PWM_STEPS + 1);
  localparam int SW = PWM_STEPS > 1 ? $clog2(PWM_STEPS) : 1;
  localparam int PW = PWM_DIV > 1 ? $clog2(PWM_DIV) : 1;
  localparam int AW = NUM_LEDS > 1 ? $clog2(NUM_LEDS) : 1;
  state_t state;
  logic rx_dv_q;
  logic [CMD_BITS-1:0] cmd_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [PAYLOAD_BITS-1:0] payload_q;
  logic [BW-1:0] bright [NUM_LEDS];
  logic [PW-1:0] pre;
  logic [SW-1:0] step;
  logic strobe, bad_addr, known;
  logic [BW-1:0] clamped;
  logic [AW-1:0] idx;
  // rx_dv idles high, so a new frame is its rising edge; rx_dv_q resets to 1 to avoid a false edge
  assign strobe = i_rx_dv & ~rx_dv_q;
  assign bad_addr = int'(addr_q) >= NUM_LEDS;
  assign known = cmd_q inside {CMD_NOP, CMD_WRITE, CMD_READ};
  assign clamped = int'(payload_q) > PWM_STEPS ? BW'(PWM_STEPS) : BW'(payload_q);
  assign idx = addr_q[AW-1:0];
  assign o_busy = state != IDLE;
  always_ff @(posedge sysclk or posedge rst)
    if (rst) begin
      state <= IDLE;
      rx_dv_q <= 1'b1;
      cmd_q <= '0;
      addr_q <= '0;
      payload_q <= '0;
      o_slv_frame <= '0;
      o_slv_tx_enb <= 1'b0;
      o_err <= 1'b0;
      for (int i = 0; i < NUM_LEDS; i++) bright[i] <= '0;
    end else begin
      rx_dv_q <= i_rx_dv;
      case (state)
        IDLE: state <= strobe ? CAPTURE : IDLE;
        CAPTURE: begin
          cmd_q <= i_cmd;
          addr_q <= i_addr;
          payload_q <= i_payload;
          o_slv_tx_enb <= 1'b0;
          state <= DECODE;
        end
        DECODE: begin
          o_err <= o_err | bad_addr | ~known;
          state <= (bad_addr || !known || cmd_q == CMD_NOP) ? IDLE : cmd_q == CMD_WRITE ? WRITE : READ;
        end
        WRITE: begin
          bright[idx] <= clamped;
          state <= IDLE;
        end
        READ: begin
          o_slv_frame <= {CMD_READ, addr_q, PAYLOAD_BITS'(bright[idx])};
          o_slv_tx_enb <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  always_ff @(posedge sysclk or posedge rst)
    if (rst) begin
      pre <= '0;
      step <= '0;
    end else begin
      pre <= pre == PW'(PWM_DIV - 1) ? '0 : pre + 1'b1;
      if (pre == PW'(PWM_DIV - 1)) step <= step == SW'(PWM_STEPS - 1) ? '0 : step + 1'b1;
    end
  for (genvar g = 0; g < NUM_LEDS; g++) begin : g_ch
    led_pwm_channel #(.SW(SW), .BW(BW)) u_ch (
      .sysclk(sysclk),
      .rst(rst),
      .step(step),
      .bright(bright[g]),
      .led(o_led[g])
    );
  end
endmodule

// File: tb/tb_led_cmd_ctrl.sv
// tb_led_cmd_ctrl: directed frames with a read-response scoreboard plus direct status and duty checks
module tb_led_cmd_ctrl;
  import led_cmd_ctrl_pkg::*;
  logic sysclk = 1'b0;
  logic rst;
  logic i_rx_dv;
  logic [7:0] i_cmd, i_addr, i_payload;
  logic [23:0] o_slv_frame;
  logic o_slv_tx_enb, o_err, o_busy;
  logic [3:0] o_led;
  int errors = 0, checks = 0;
  int cnt [4];
  logic [23:0] sb [$];
  logic prev_tx = 1'b0;
  always #5 sysclk = ~sysclk;
  led_cmd_ctrl #(.NUM_LEDS(4), .PWM_STEPS(100), .PWM_DIV(2)) dut (
    .sysclk(sysclk),
    .rst(rst),
    .i_rx_dv(i_rx_dv),
    .i_cmd(i_cmd),
    .i_addr(i_addr),
    .i_payload(i_payload),
    .o_slv_frame(o_slv_frame),
    .o_slv_tx_enb(o_slv_tx_enb),
    .o_led(o_led),
    .o_err(o_err),
    .o_busy(o_busy)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge sysclk) begin
    if (o_slv_tx_enb && !prev_tx) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got frame %06h with no read pending", o_slv_frame);
      end else begin
        logic [23:0] e;
        e = sb.pop_front();
        if (o_slv_frame !== e) begin
          errors++;
          $display("FAIL sb_frame: got %06h expected %06h", o_slv_frame, e);
        end
      end
    end
    prev_tx <= o_slv_tx_enb;
  end
  task automatic send(input logic [7:0] c, input logic [7:0] a, input logic [7:0] p);
    @(negedge sysclk);
    i_cmd = c;
    i_addr = a;
    i_payload = p;
    i_rx_dv = 1'b0;
    repeat (3) @(negedge sysclk);
    i_rx_dv = 1'b1;
    repeat (8) @(negedge sysclk);
  endtask
  task automatic rd(input logic [7:0] a, input logic [7:0] b);
    sb.push_back({CMD_READ, a, b});
    send(CMD_READ, a, 8'h00);
  endtask
  task automatic measure;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    repeat (200) begin
      @(negedge sysclk);
      for (int i = 0; i < 4; i++) cnt[i] += int'(o_led[i]);
    end
  endtask
  initial begin
    rst = 1'b1;
    i_rx_dv = 1'b1;
    i_cmd = '0;
    i_addr = '0;
    i_payload = '0;
    repeat (3) @(negedge sysclk);
    rst = 1'b0;
    repeat (10) @(negedge sysclk);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_led", 32'(o_led), 0);
    chk("rst_frame", 32'(o_slv_frame), 0);
    chk("rst_tx_enb", 32'(o_slv_tx_enb), 0);
    chk("rst_err", 32'(o_err), 0);
    send(CMD_WRITE, 8'd2, 8'd50);
    measure();
    chk("duty_led2_50", 32'(cnt[2]), 100);
    chk("duty_led0_off", 32'(cnt[0]), 0);
    send(CMD_WRITE, 8'd1, 8'd200);
    chk("clamp_no_err", 32'(o_err), 0);
    measure();
    chk("duty_led1_full", 32'(cnt[1]), 200);
    chk("duty_led2_kept", 32'(cnt[2]), 100);
    chk("duty_led3_off", 32'(cnt[3]), 0);
    rd(8'd2, 8'd50);
    rd(8'd1, 8'd100);
    send(CMD_WRITE, 8'd3, 8'd75);
    rd(8'd3, 8'd75);
    chk("read3_frame", 32'(o_slv_frame), 32'h02034B);
    chk("read3_tx_enb", 32'(o_slv_tx_enb), 1);
    send(CMD_NOP, 8'd0, 8'd0);
    chk("tx_enb_cleared", 32'(o_slv_tx_enb), 0);
    chk("nop_no_err", 32'(o_err), 0);
    send(CMD_WRITE, 8'd7, 8'd40);
    chk("bad_addr_err", 32'(o_err), 1);
    rd(8'd3, 8'd75);
    @(negedge sysclk);
    i_cmd = CMD_WRITE;
    i_addr = 8'd0;
    i_payload = 8'd60;
    i_rx_dv = 1'b0;
    repeat (3) @(negedge sysclk);
    i_rx_dv = 1'b1;
    repeat (2) @(negedge sysclk);
    chk("busy_in_decode", 32'(o_busy), 1);
    rst = 1'b1;
    #1;
    chk("async_busy", 32'(o_busy), 0);
    chk("async_tx_enb", 32'(o_slv_tx_enb), 0);
    @(negedge sysclk);
    rst = 1'b0;
    repeat (4) @(negedge sysclk);
    chk("post_rst_err", 32'(o_err), 0);
    chk("post_rst_led", 32'(o_led), 0);
    rd(8'd0, 8'd0);
    rd(8'd1, 8'd0);
    send(8'hFF, 8'd0, 8'd30);
    chk("bad_cmd_err", 32'(o_err), 1);
    rd(8'd0, 8'd0);
    measure();
    chk("led0_after_bad_cmd", 32'(cnt[0]), 0);
    repeat (10) @(negedge sysclk);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
